// File: rtl/cfo_phase_rotator.sv
// Carrier-offset phase rotator: quadrant pre-rotation followed by a pipelined rotation-mode CORDIC.
// Define PHASE_ROT_GAIN_COMP_EN to add a registered CORDIC gain-compensation multiply (unity gain).
`timescale 1ns/1ps
module cfo_phase_rotator #(
    parameter int DATA_W = 16,
    parameter int ITER   = 16,
    parameter int GUARD  = 2
) (
    input  logic                     CLK,
    input  logic                     a_RSTn,
    input  logic                     Input_Strobe,
    input  logic signed [DATA_W-1:0] I_In,
    input  logic signed [DATA_W-1:0] Q_In,
    input  logic signed [31:0]       Phase_In,
    output logic signed [DATA_W-1:0] I_Out,
    output logic signed [DATA_W-1:0] Q_Out,
    output logic                     Output_Strobe
);

    // Fraction bits below the sample LSB keep per-stage shift truncation well under one output LSB.
    localparam int FRAC = 4;
    localparam int W    = DATA_W + GUARD + FRAC;
    localparam int PW   = W + 16;

    localparam logic signed [31:0] HALF_PI = 32'sh1921FB54;

    // round(atan(2^-i) * 2^28)
    localparam logic signed [31:0] ATAN [0:19] = '{
        32'sh0C90FDAA, 32'sh076B19C1, 32'sh03EB6EBF, 32'sh01FD5BAA,
        32'sh00FFAADE, 32'sh007FF557, 32'sh003FFEAB, 32'sh001FFFD5,
        32'sh000FFFFB, 32'sh0007FFFF, 32'sh00040000, 32'sh00020000,
        32'sh00010000, 32'sh00008000, 32'sh00004000, 32'sh00002000,
        32'sh00001000, 32'sh00000800, 32'sh00000400, 32'sh00000200
    };

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [PW-1:0] v);
        if (v[PW-1:DATA_W-1] == '0 || v[PW-1:DATA_W-1] == '1)
            return v[DATA_W-1:0];
        else if (v[PW-1])
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    logic signed [W-1:0]  i_ext, q_ext;
    logic signed [W-1:0]  x_pre, y_pre;
    logic signed [31:0]   z_pre;

    logic signed [W-1:0]  x_pipe [0:ITER];
    logic signed [W-1:0]  y_pipe [0:ITER];
    logic signed [31:0]   z_pipe [0:ITER-1];
    logic [ITER:0]        valid;

    always_comb begin
        i_ext = {{GUARD{I_In[DATA_W-1]}}, I_In, {FRAC{1'b0}}};
        q_ext = {{GUARD{Q_In[DATA_W-1]}}, Q_In, {FRAC{1'b0}}};
        x_pre = i_ext;
        y_pre = q_ext;
        z_pre = Phase_In;
        if (Phase_In > HALF_PI) begin
            x_pre = -q_ext;
            y_pre = i_ext;
            z_pre = Phase_In - HALF_PI;
        end else if (Phase_In < -HALF_PI) begin
            x_pre = q_ext;
            y_pre = -i_ext;
            z_pre = Phase_In + HALF_PI;
        end
    end

    always_ff @(posedge CLK or negedge a_RSTn) begin
        if (!a_RSTn) begin
            for (int unsigned i = 0; i <= ITER; i++) begin
                x_pipe[i] <= '0;
                y_pipe[i] <= '0;
            end
            for (int unsigned i = 0; i < ITER; i++)
                z_pipe[i] <= '0;
            valid <= '0;
        end else begin
            valid     <= {valid[ITER-1:0], Input_Strobe};
            x_pipe[0] <= x_pre;
            y_pipe[0] <= y_pre;
            z_pipe[0] <= z_pre;
            for (int unsigned i = 0; i < ITER; i++) begin
                if (z_pipe[i][31]) begin
                    x_pipe[i+1] <= x_pipe[i] + (y_pipe[i] >>> i);
                    y_pipe[i+1] <= y_pipe[i] - (x_pipe[i] >>> i);
                end else begin
                    x_pipe[i+1] <= x_pipe[i] - (y_pipe[i] >>> i);
                    y_pipe[i+1] <= y_pipe[i] + (x_pipe[i] >>> i);
                end
            end
            for (int unsigned i = 0; i + 1 < ITER; i++)
                z_pipe[i+1] <= z_pipe[i][31] ? z_pipe[i] + ATAN[i] : z_pipe[i] - ATAN[i];
        end
    end

`ifdef PHASE_ROT_GAIN_COMP_EN
    localparam logic signed [15:0]   K     = 16'sd19898;
    localparam logic signed [PW-1:0] ROUND = PW'(1) <<< (14 + FRAC);

    logic signed [PW-1:0] prod_x, prod_y, rnd_x, rnd_y;

    always_comb begin
        prod_x = PW'(x_pipe[ITER]) * PW'(K);
        prod_y = PW'(y_pipe[ITER]) * PW'(K);
        rnd_x  = (prod_x + ROUND) >>> (15 + FRAC);
        rnd_y  = (prod_y + ROUND) >>> (15 + FRAC);
    end

    always_ff @(posedge CLK or negedge a_RSTn) begin
        if (!a_RSTn) begin
            I_Out         <= '0;
            Q_Out         <= '0;
            Output_Strobe <= 1'b0;
        end else begin
            I_Out         <= saturate(rnd_x);
            Q_Out         <= saturate(rnd_y);
            Output_Strobe <= valid[ITER];
        end
    end
`else
    // Uncompensated: halve the CORDIC gain (~0.823 net); cleared pipeline gives zero outputs in reset.
    always_comb begin
        I_Out         = saturate(PW'(x_pipe[ITER] >>> (FRAC + 1)));
        Q_Out         = saturate(PW'(y_pipe[ITER] >>> (FRAC + 1)));
        Output_Strobe = valid[ITER];
    end
`endif

endmodule

// File: tb/tb_cfo_phase_rotator.sv
// Directed bench for cfo_phase_rotator: latency, quadrant branches, sweep, saturation, mid-stream reset.
`timescale 1ns/1ps
module tb_cfo_phase_rotator;

    localparam int DATA_W = 16;
    localparam int ITER   = 16;
    localparam int GUARD  = 2;
`ifdef PHASE_ROT_GAIN_COMP_EN
    localparam int LAT   = ITER + 2;
    localparam int A1000 = 1000;
    localparam int A707  = 707;
`else
    localparam int LAT   = ITER + 1;
    localparam int A1000 = 823;
    localparam int A707  = 582;
`endif

    logic                     CLK = 1'b0;
    logic                     a_RSTn;
    logic                     Input_Strobe;
    logic signed [DATA_W-1:0] I_In, Q_In;
    logic signed [31:0]       Phase_In;
    logic signed [DATA_W-1:0] I_Out, Q_Out;
    logic                     Output_Strobe;

    typedef struct {
        int cyc;
        int ei;
        int eq;
        int tol;
        int id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   next_id = 0;
    real  gain;

    cfo_phase_rotator #(.DATA_W(DATA_W), .ITER(ITER), .GUARD(GUARD)) dut (
        .CLK(CLK),
        .a_RSTn(a_RSTn),
        .Input_Strobe(Input_Strobe),
        .I_In(I_In),
        .Q_In(Q_In),
        .Phase_In(Phase_In),
        .I_Out(I_Out),
        .Q_Out(Q_Out),
        .Output_Strobe(Output_Strobe)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int want, input int tol);
        checks++;
        if (got - want > tol || want - got > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, want, tol);
        end
    endtask

    function automatic int sat16(input real r);
        int v = int'(r);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    function automatic real angle(input logic [31:0] ph);
        return $itor($signed(ph)) / 268435456.0;
    endfunction

    function automatic int model_i(input int i, input int q, input logic [31:0] ph);
        return sat16(gain * (i * $cos(angle(ph)) - q * $sin(angle(ph))));
    endfunction

    function automatic int model_q(input int i, input int q, input logic [31:0] ph);
        return sat16(gain * (i * $sin(angle(ph)) + q * $cos(angle(ph))));
    endfunction

    always @(negedge CLK) begin
        if (Output_Strobe === 1'b1) begin
            if (sb.size() == 0) begin
                check("stray_strobe", 1, 0, 0);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("s%0d_latency", mon_e.id), cyc, mon_e.cyc, 0);
                check($sformatf("s%0d_i", mon_e.id), int'(I_Out), mon_e.ei, mon_e.tol);
                check($sformatf("s%0d_q", mon_e.id), int'(Q_Out), mon_e.eq, mon_e.tol);
            end
        end
    end

    task automatic issue(input int i, input int q, input logic [31:0] ph,
                         input int ei, input int eq, input int tol);
        exp_t e;
        @(negedge CLK);
        #1;
        Input_Strobe = 1'b1;
        I_In         = 16'(i);
        Q_In         = 16'(q);
        Phase_In     = ph;
        e.cyc = cyc + LAT;
        e.ei  = ei;
        e.eq  = eq;
        e.tol = tol;
        e.id  = next_id;
        next_id++;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
            Input_Strobe = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 4 * LAT) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0, 0);
            sb.delete();
        end
    endtask

    initial begin
        logic [31:0] ph;
        real an = 1.0;
        a_RSTn       = 1'b0;
        Input_Strobe = 1'b0;
        I_In         = '0;
        Q_In         = '0;
        Phase_In     = '0;
        for (int i = 0; i < ITER; i++)
            an = an * $sqrt(1.0 + 2.0 ** (-2.0 * i));
`ifdef PHASE_ROT_GAIN_COMP_EN
        gain = 1.0;
`else
        gain = an / 2.0;
`endif

        repeat (3) @(negedge CLK);
        check("rst_i", int'(I_Out), 0, 0);
        check("rst_q", int'(Q_Out), 0, 0);
        check("rst_strobe", int'(Output_Strobe), 0, 0);
        #1 a_RSTn = 1'b1;
        idle(2);

        issue(1000, 0, 32'h00000000, A1000, 0, 2);
        idle(1);
        drain();
        idle(LAT);

        issue(1000, 0, 32'h1921FB54, 0, A1000, 2);
        issue(1000, 0, 32'h3243F6A8, -A1000, 0, 2);
        issue(1000, 0, 32'hE6DE04AC, 0, -A1000, 2);
        issue(1000, 0, 32'hCDBC0958, -A1000, 0, 2);
        issue(0, 1000, 32'h00000000, 0, A1000, 2);
        issue(1000, 0, 32'h0C90FDAA, A707, A707, 2);
        idle(1);
        drain();

        for (int k = 0; k < 64; k++) begin
            ph = 32'hCDBC0958 + (32'(k) << 24);
            issue(8000, 8000, ph, model_i(8000, 8000, ph), model_q(8000, 8000, ph), 2);
        end
        idle(1);
        drain();

        issue(32767, 32767, 32'h0C90FDAA, 0, 32767, 2);
        issue(-32768, -32768, 32'h0C90FDAA, 0, -32768, 2);
        idle(1);
        drain();

        for (int k = 0; k < 5; k++) begin
            issue(1000, 0, 32'h00000000, A1000, 0, 2);
            idle(1);
        end
        @(negedge CLK);
        #2 a_RSTn = 1'b0;
        #1;
        check("midrst_i", int'(I_Out), 0, 0);
        check("midrst_q", int'(Q_Out), 0, 0);
        check("midrst_strobe", int'(Output_Strobe), 0, 0);
        sb.delete();
        #7 a_RSTn = 1'b1;
        idle(2 * LAT);
        issue(1000, 0, 32'h00000000, A1000, 0, 2);
        idle(1);
        drain();
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
